calc_core_param: RTL and testbench

Parameterised successor of the team's calculator core. It accepts strobed 4-bit keypad commands and builds DIGITS-wide decimal operands. It performs signed add, subtract and shift-add multiply, supports chained operators, and converts results to BCD with a sequential double-dabble. It sits between the keypad decoder and the 7-segment display driver.

---
 rtl/calc_core_param.sv | 237 +++++++++++++++++++++++
 tb/tb_calc_core_param.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/calc_core_param.sv
// Parameterised keypad calculator core: decimal operand entry, signed add/sub/multiply
// with chained operators, and sequential binary-to-BCD conversion for the display.
module calc_core_param #(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 27
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            cmd,
  input  logic                  cmd_valid,
  output logic [4*DIGITS-1:0]   digit_bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  neg,
  output logic [1:0]            status,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0, ENTER_B = 3'd1, MUL = 3'd2, EXEC = 3'd3,
    CONV    = 3'd4, RESULT  = 3'd5, ERROR = 3'd6
  } state_t;

  localparam int CW = $clog2(DIGITS + 1);
  localparam int KW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  localparam logic [1:0] OP_MUL = 2'b00;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [2*WIDTH-1:0] MAX_MAG = (2*WIDTH)'(pow10(DIGITS) - 64'd1);

  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      MUL, EXEC, CONV: return 2'b01;
      ERROR:           return 2'b10;
      default:         return 2'b00;
    endcase
  endfunction

  // Leading-zero blanking: a digit is lit if it or any more significant digit is non-zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] bcd);
    logic              seen;
    logic [DIGITS-1:0] m;
    seen = 1'b0;
    m    = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (bcd[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  function automatic logic [4*DIGITS-1:0] dd_step(input logic [4*DIGITS-1:0] bcd, input logic b);
    logic [4*DIGITS-1:0] t;
    t = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[4*DIGITS-2:0], b};
  endfunction

  state_t                state_r;
  logic [WIDTH-1:0]      ent_r, a_mag_r, b_mag_r, conv_bin_r;
  logic [CW-1:0]         cnt_r;
  logic                  b_any_r, a_neg_r, chain_r;
  logic [1:0]            op_r, pend_r;
  logic [2*WIDTH-1:0]    prod_r;
  logic [KW-1:0]         step_r;
  logic [4*DIGITS-1:0]   conv_bcd_r;

  logic                  is_dig_s, is_op_s, clr_s;
  logic [1:0]            cmd_op_s;
  logic [WIDTH-1:0]      new_ent_s;
  logic [4*DIGITS-1:0]   disp_s, conv_step_s;
  logic [WIDTH:0]        mul_sum_s;
  logic signed [WIDTH+1:0] sa_s, sb_s, sum_s;
  logic [WIDTH+1:0]      abs_s;
  logic [2*WIDTH-1:0]    exec_mag_s;
  logic                  exec_neg_s;

  assign status = status_of(state_r);
  assign state  = state_r;

  // Command decode, digit accumulation and arithmetic datapath feeding the FSM.
  always_comb begin
    is_dig_s    = (cmd <= 4'd9);
    is_op_s     = (cmd == 4'd10) || (cmd == 4'd11) || (cmd == 4'd12);
    cmd_op_s    = cmd[1:0];
    clr_s       = cmd_valid && (cmd == 4'd15) && (status != 2'b01);
    new_ent_s   = ent_r * WIDTH'(4'd10) + {{(WIDTH-4){1'b0}}, cmd};
    disp_s      = (state_r == ENTER_B && !b_any_r) ? {{(4*DIGITS-4){1'b0}}, cmd}
                                                   : {digit_bcd[4*DIGITS-5:0], cmd};
    conv_step_s = dd_step(conv_bcd_r, conv_bin_r[WIDTH-1]);
    mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                + (prod_r[0] ? {1'b0, a_mag_r} : {(WIDTH+1){1'b0}});
    sa_s        = a_neg_r ? -$signed({2'b00, a_mag_r}) : $signed({2'b00, a_mag_r});
    sb_s        = $signed({2'b00, b_mag_r});
    sum_s       = (op_r == OP_SUB) ? (sa_s - sb_s) : (sa_s + sb_s);
    abs_s       = sum_s[WIDTH+1] ? -sum_s : sum_s;
    if (op_r == OP_MUL) begin
      exec_mag_s = prod_r;
      exec_neg_s = a_neg_r;
    end else begin
      exec_mag_s = {{(WIDTH-2){1'b0}}, abs_s};
      exec_neg_s = sum_s[WIDTH+1];
    end
  end

  // Main calculator FSM with registered display outputs.
  always_ff @(posedge clock) begin
    if (reset || clr_s) begin
      state_r    <= ENTER_A;
      ent_r      <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      b_any_r    <= 1'b0;
      a_mag_r    <= {WIDTH{1'b0}};
      a_neg_r    <= 1'b0;
      b_mag_r    <= {WIDTH{1'b0}};
      op_r       <= OP_ADD;
      pend_r     <= OP_ADD;
      chain_r    <= 1'b0;
      prod_r     <= {(2*WIDTH){1'b0}};
      step_r     <= {KW{1'b0}};
      conv_bin_r <= {WIDTH{1'b0}};
      conv_bcd_r <= {(4*DIGITS){1'b0}};
      digit_bcd  <= {(4*DIGITS){1'b0}};
      digit_en   <= {{(DIGITS-1){1'b0}}, 1'b1};
      neg        <= 1'b0;
    end else begin
      case (state_r)
        ENTER_A, ENTER_B: begin
          if (cmd_valid && is_dig_s) begin
            if (cnt_r < CW'(DIGITS)) begin
              ent_r     <= new_ent_s;
              if (new_ent_s != {WIDTH{1'b0}}) cnt_r <= cnt_r + CW'(1);
              digit_bcd <= disp_s;
              digit_en  <= lz_mask(disp_s);
              neg       <= 1'b0;
              b_any_r   <= (state_r == ENTER_B);
            end
          end else if (cmd_valid && is_op_s && state_r == ENTER_A) begin
            a_mag_r <= ent_r;
            a_neg_r <= neg;
            op_r    <= cmd_op_s;
            ent_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            b_any_r <= 1'b0;
            state_r <= ENTER_B;
          end else if (cmd_valid && state_r == ENTER_B &&
                       ((is_op_s && b_any_r) || cmd == 4'd14)) begin
            // Launch A op B; an operator here chains the new op after the result.
            chain_r <= is_op_s;
            pend_r  <= cmd_op_s;
            b_mag_r <= ent_r;
            step_r  <= {KW{1'b0}};
            prod_r  <= {{WIDTH{1'b0}}, ent_r};
            state_r <= (op_r == OP_MUL) ? MUL : EXEC;
          end else if (cmd_valid && is_op_s && state_r == ENTER_B) begin
            op_r <= cmd_op_s;
          end
        end
        MUL: begin
          prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
          step_r <= step_r + KW'(1);
          if (step_r == KW'(WIDTH - 1)) state_r <= EXEC;
        end
        EXEC: begin
          if (exec_mag_s > MAX_MAG) begin
            digit_bcd <= {(4*DIGITS){1'b0}};
            digit_en  <= {DIGITS{1'b0}};
            neg       <= 1'b0;
            chain_r   <= 1'b0;
            state_r   <= ERROR;
          end else begin
            a_mag_r    <= exec_mag_s[WIDTH-1:0];
            a_neg_r    <= exec_neg_s && (exec_mag_s != {(2*WIDTH){1'b0}});
            conv_bin_r <= exec_mag_s[WIDTH-1:0];
            conv_bcd_r <= {(4*DIGITS){1'b0}};
            step_r     <= {KW{1'b0}};
            state_r    <= CONV;
          end
        end
        CONV: begin
          if (step_r == KW'(WIDTH - 1)) begin
            digit_bcd <= conv_step_s;
            digit_en  <= lz_mask(conv_step_s);
            neg       <= a_neg_r;
            if (chain_r) begin
              op_r    <= pend_r;
              chain_r <= 1'b0;
              ent_r   <= {WIDTH{1'b0}};
              cnt_r   <= {CW{1'b0}};
              b_any_r <= 1'b0;
              state_r <= ENTER_B;
            end else begin
              state_r <= RESULT;
            end
          end else begin
            conv_bcd_r <= conv_step_s;
            conv_bin_r <= {conv_bin_r[WIDTH-2:0], 1'b0};
            step_r     <= step_r + KW'(1);
          end
        end
        RESULT: begin
          if (cmd_valid && is_dig_s) begin
            ent_r     <= {{(WIDTH-4){1'b0}}, cmd};
            cnt_r     <= (cmd != 4'd0) ? CW'(1) : CW'(0);
            digit_bcd <= {{(4*DIGITS-4){1'b0}}, cmd};
            digit_en  <= {{(DIGITS-1){1'b0}}, 1'b1};
            neg       <= 1'b0;
            state_r   <= ENTER_A;
          end else if (cmd_valid && is_op_s) begin
            op_r    <= cmd_op_s;
            ent_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            b_any_r <= 1'b0;
            state_r <= ENTER_B;
          end
        end
        ERROR: begin
          state_r <= ERROR;
        end
        default: begin
          state_r <= ENTER_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core_param.sv
// Directed self-checking bench for calc_core_param (DIGITS=8, WIDTH=27).
module tb_calc_core_param;

  localparam int DIGITS = 8;
  localparam int WIDTH  = 27;

  logic                clock = 1'b0;
  logic                reset;
  logic [3:0]          cmd;
  logic                cmd_valid;
  logic [4*DIGITS-1:0] digit_bcd;
  logic [DIGITS-1:0]   digit_en;
  logic                neg;
  logic [1:0]          status;
  logic [2:0]          state;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  calc_core_param #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .digit_bcd(digit_bcd), .digit_en(digit_en), .neg(neg),
    .status(status), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] c);
    @(negedge clock);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (status == 2'b01 && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_status", status, 2'b00);
    check("rst_bcd", digit_bcd, 32'h0);
    check("rst_en", digit_en, 8'h01);
    check("rst_neg", neg, 1'b0);

    // 123 + 1
    send(4'd1); send(4'd2); send(4'd3);
    check("entry_bcd", digit_bcd, 32'h123);
    check("entry_en", digit_en, 8'h07);
    send(4'd10);
    check("op_keeps_a", digit_bcd, 32'h123);
    send(4'd1); send(4'd14);
    check("busy_hold", digit_bcd, 32'h1);
    wait_ready(n);
    check("add_busy", n, 28);
    check("add_bcd", digit_bcd, 32'h124);
    check("add_en", digit_en, 8'h07);
    check("add_neg", neg, 1'b0);
    check("add_state", state, 3'd5);

    // 5 - 9 = -4, then -4 + 4 = 0
    send(4'd15);
    check("clr_bcd", digit_bcd, 32'h0);
    send(4'd5); send(4'd11); send(4'd9); send(4'd14);
    wait_ready(n);
    check("sub_bcd", digit_bcd, 32'h4);
    check("sub_neg", neg, 1'b1);
    send(4'd10); send(4'd4); send(4'd14);
    wait_ready(n);
    check("zero_bcd", digit_bcd, 32'h0);
    check("zero_neg", neg, 1'b0);
    check("zero_en", digit_en, 8'h01);

    // 6 * 2 with a dropped strobe mid-multiply
    send(4'd15);
    send(4'd6); send(4'd12); send(4'd2); send(4'd14);
    n = 0;
    while (status == 2'b01 && n < 200) begin
      @(negedge clock);
      n++;
      if (n == 10) begin
        cmd = 4'd3; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (n == 20) check("mul_hold", digit_bcd, 32'h2);
    end
    cmd_valid = 1'b0;
    check("mul_busy", n, 55);
    check("mul_bcd", digit_bcd, 32'h12);
    check("mul_en", digit_en, 8'h03);

    // chained 2 + 3 * 4
    send(4'd15);
    send(4'd2); send(4'd10); send(4'd3); send(4'd12);
    wait_ready(n);
    check("chain_bcd", digit_bcd, 32'h5);
    check("chain_state", state, 3'd1);
    send(4'd4);
    check("chain_b", digit_bcd, 32'h4);
    send(4'd14);
    wait_ready(n);
    check("chain_res", digit_bcd, 32'h20);
    check("chain_rstate", state, 3'd5);

    // overflow
    send(4'd15);
    for (int i = 0; i < 9; i++) send(4'd9);
    check("max_bcd", digit_bcd, 32'h99999999);
    check("max_en", digit_en, 8'hFF);
    send(4'd10); send(4'd1); send(4'd14);
    wait_ready(n);
    check("ovf_state", state, 3'd6);
    check("ovf_status", status, 2'b10);
    check("ovf_en", digit_en, 8'h00);
    check("ovf_bcd", digit_bcd, 32'h0);
    send(4'd5);
    check("err_dig_state", state, 3'd6);
    check("err_dig_en", digit_en, 8'h00);
    send(4'd15);
    check("err_clr_state", state, 3'd0);
    check("err_clr_status", status, 2'b00);
    check("err_clr_en", digit_en, 8'h01);

    // reset during multiply
    send(4'd6); send(4'd12); send(4'd2); send(4'd14);
    repeat (5) @(negedge clock);
    check("pre_rst_busy", status, 2'b01);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst_state", state, 3'd0);
    check("mrst_status", status, 2'b00);
    check("mrst_bcd", digit_bcd, 32'h0);
    check("mrst_neg", neg, 1'b0);
    send(4'd7); send(4'd10); send(4'd10); send(4'd11); send(4'd3); send(4'd14);
    wait_ready(n);
    check("oprep_bcd", digit_bcd, 32'h4);
    check("oprep_neg", neg, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
